lsu_engine: RTL and testbench

Load/store unit between the core's memory stage and the word-organised data memory engine. It accepts one byte, halfword or word access per request and converts it to word-aligned memory transactions. Sub-word stores are done as read-modify-write. Loads return sign- or zero-extended data. Misaligned or illegal accesses are rejected without touching memory.

---
 rtl/lsu_pkg.sv | 37 +++
 rtl/lsu_lane_align.sv | 39 +++
 rtl/lsu_engine.sv | 103 ++++++++++
 tb/tb_lsu_engine.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings, FSM states
// and the legality check applied to every incoming request.
package lsu_pkg;

    localparam int LSU_WIDTH = 32;
    localparam int LANE_W    = 8;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_RMW_READ = 3'd2,
        ST_WRITE    = 3'd3,
        ST_RESP     = 3'd4
    } state_e;

    // Unsigned sizes only make sense for loads; halfwords and words need natural alignment.
    function automatic logic isIllegal(input logic we, input logic [2:0] funct3,
                                       input logic [1:0] addrLo);
        logic bad;
        case (funct3)
            F3_B:    bad = 1'b0;
            F3_H:    bad = addrLo[0];
            F3_W:    bad = (addrLo != 2'b00);
            F3_BU:   bad = we;
            F3_HU:   bad = we | addrLo[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: extracts and extends load data, and merges
// sub-word store data into a full memory word for read-modify-write.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [LSU_WIDTH-1:0] word_i,
    input  logic [1:0]           addrLo_i,
    input  logic [2:0]           funct3_i,
    input  logic [LSU_WIDTH-1:0] wdata_i,
    output logic [LSU_WIDTH-1:0] loadData_o,
    output logic [LSU_WIDTH-1:0] mergedWord_o
);

    logic [LANE_W-1:0]   byteSel;
    logic [2*LANE_W-1:0] halfSel;

    // Little-endian lanes: byte offset 0 lives in bits [7:0].
    always_comb begin
        byteSel = word_i[{addrLo_i, 3'b000} +: LANE_W];
        halfSel = addrLo_i[1] ? word_i[31:16] : word_i[15:0];
        case (funct3_i)
            F3_B:    loadData_o = {{(LSU_WIDTH-LANE_W){byteSel[LANE_W-1]}}, byteSel};
            F3_BU:   loadData_o = {{(LSU_WIDTH-LANE_W){1'b0}}, byteSel};
            F3_H:    loadData_o = {{(LSU_WIDTH-2*LANE_W){halfSel[2*LANE_W-1]}}, halfSel};
            F3_HU:   loadData_o = {{(LSU_WIDTH-2*LANE_W){1'b0}}, halfSel};
            default: loadData_o = word_i;
        endcase
    end

    always_comb begin
        mergedWord_o = word_i;
        if (funct3_i == F3_H) begin
            mergedWord_o[{addrLo_i[1], 4'b0000} +: 2*LANE_W] = wdata_i[2*LANE_W-1:0];
        end else begin
            mergedWord_o[{addrLo_i, 3'b000} +: LANE_W] = wdata_i[LANE_W-1:0];
        end
    end

endmodule

// File: rtl/lsu_engine.sv
// Load/store unit: turns one byte/halfword/word core request into word-aligned
// memory transactions, doing read-modify-write for sub-word stores.
module lsu_engine
    import lsu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int ADDR_LSB = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [2:0]       req_funct3,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             resp_valid,
    output logic             resp_err,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             mem_read_en,
    output logic             mem_write_en,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_write_data,
    input  logic [WIDTH-1:0] mem_read_data
);

    state_e           state_q;
    logic             we_q;
    logic [2:0]       funct3_q;
    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] wword_q;
    logic [WIDTH-1:0] rdata_q;
    logic             err_q;

    logic [WIDTH-1:0] loadData_d;
    logic [WIDTH-1:0] mergedWord_d;

    lsu_lane_align uAlign (
        .word_i       (mem_read_data),
        .addrLo_i     (addr_q[1:0]),
        .funct3_i     (funct3_q),
        .wdata_i      (wword_q),
        .loadData_o   (loadData_d),
        .mergedWord_o (mergedWord_d)
    );

    // wword_q starts as the raw store data and is overwritten by the merged word on RMW.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wword_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        funct3_q <= req_funct3;
                        addr_q   <= req_addr;
                        wword_q  <= req_wdata;
                        rdata_q  <= '0;
                        err_q    <= 1'b0;
                        if (isIllegal(req_we, req_funct3, req_addr[1:0])) begin
                            err_q   <= 1'b1;
                            state_q <= ST_RESP;
                        end else if (!req_we) begin
                            state_q <= ST_LOAD;
                        end else if (req_funct3 == F3_W) begin
                            state_q <= ST_WRITE;
                        end else begin
                            state_q <= ST_RMW_READ;
                        end
                    end
                end
                ST_LOAD: begin
                    rdata_q <= loadData_d;
                    state_q <= ST_RESP;
                end
                ST_RMW_READ: begin
                    wword_q <= mergedWord_d;
                    state_q <= ST_WRITE;
                end
                ST_WRITE: state_q <= ST_RESP;
                ST_RESP:  state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready      = (state_q == ST_IDLE);
    assign resp_valid     = (state_q == ST_RESP);
    assign resp_err       = err_q;
    assign resp_rdata     = rdata_q;
    assign mem_read_en    = (state_q == ST_LOAD) || (state_q == ST_RMW_READ);
    assign mem_write_en   = (state_q == ST_WRITE) && we_q;
    assign mem_addr       = {{ADDR_LSB{1'b0}}, addr_q[WIDTH-1:ADDR_LSB]};
    assign mem_write_data = (state_q == ST_WRITE) ? wword_q : '0;

endmodule

// File: tb/tb_lsu_engine.sv
// Scoreboard bench for lsu_engine: requests push expected responses, a negedge
// monitor pops and compares them, and a small word memory backs the DUT.
module tb_lsu_engine;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cycle;
    } exp_t;

    exp_t        expQ[$];
    int          cycle = 0;
    int          checksTotal = 0;
    int          checksPassed = 0;
    int          readCount = 0;
    int          writeCount = 0;
    logic [31:0] lastWAddr = '0;
    logic [31:0] lastWData = '0;
    logic [31:0] memArr [0:255];

    lsu_engine #(.WIDTH(32), .ADDR_LSB(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_err       (resp_err),
        .resp_rdata     (resp_rdata),
        .mem_read_en    (mem_read_en),
        .mem_write_en   (mem_write_en),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    assign mem_read_data = memArr[mem_addr[7:0]];

    always @(posedge clk) begin
        if (mem_write_en) memArr[mem_addr[7:0]] <= mem_write_data;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checksTotal++;
        if (observed === expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)",
                     tag, observed, expected, cycle);
        end
    endtask

    // Memory traffic and response scoreboard, sampled away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            if (mem_read_en) readCount++;
            if (mem_write_en) begin
                writeCount++;
                lastWAddr = mem_addr;
                lastWData = mem_write_data;
            end
            if (resp_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("spurious_resp", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = expQ.pop_front();
                    checkOutput("resp_rdata", resp_rdata, e.rdata);
                    checkOutput("resp_err", {31'b0, resp_err}, {31'b0, e.err});
                    checkOutput("resp_cycle", cycle, e.cycle);
                end
            end
        end
    end

    // Drives one request and returns after the accepting edge; lat counts edges to resp_valid.
    task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] expRdata,
                                 input logic expErr, input int lat, input bit track,
                                 output int acc);
        int guard;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            acc = -1;
        end else begin
            acc = cycle + 1;
            if (track) expQ.push_back('{expRdata, expErr, acc + lat - 1});
            @(posedge clk);
            #1 req_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (expQ.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (expQ.size() != 0) begin
            checkOutput("drain_timeout", expQ.size(), 32'd0);
            expQ.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acc1;
        int acc2;
        int rdSnap;
        int wrSnap;

        rst        = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = '0;
        req_wdata  = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst_req_ready", {31'b0, req_ready}, 32'd1);
        checkOutput("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        checkOutput("rst_mem_read_en", {31'b0, mem_read_en}, 32'd0);
        checkOutput("rst_mem_write_en", {31'b0, mem_write_en}, 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        checkOutput("rst_resp_rdata", resp_rdata, 32'd0);
        rst = 1'b1;

        // Word store then word load.
        wrSnap = writeCount;
        applyStimulus(1'b1, F3_W, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1'b1, acc1);
        drain();
        checkOutput("sw_write_cycles", writeCount - wrSnap, 32'd1);
        checkOutput("sw_write_addr", lastWAddr, 32'h4);
        checkOutput("sw_write_data", lastWData, 32'hDEADBEEF);
        applyStimulus(1'b0, F3_W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1'b1, acc1);
        drain();

        // Sub-word store as read-modify-write.
        applyStimulus(1'b1, F3_W, 32'h10, 32'h11223344, 32'h0, 1'b0, 2, 1'b1, acc1);
        drain();
        rdSnap = readCount;
        wrSnap = writeCount;
        applyStimulus(1'b1, F3_B, 32'h12, 32'h000000AB, 32'h0, 1'b0, 3, 1'b1, acc1);
        drain();
        checkOutput("sb_read_cycles", readCount - rdSnap, 32'd1);
        checkOutput("sb_write_cycles", writeCount - wrSnap, 32'd1);
        checkOutput("sb_write_data", lastWData, 32'h11AB3344);
        applyStimulus(1'b0, F3_W, 32'h10, 32'h0, 32'h11AB3344, 1'b0, 2, 1'b1, acc1);
        drain();

        // Load extension over every lane/size combination of interest.
        applyStimulus(1'b1, F3_W, 32'h20, 32'h80FF7F01, 32'h0, 1'b0, 2, 1'b1, acc1);
        applyStimulus(1'b0, F3_B,  32'h23, 32'h0, 32'hFFFFFF80, 1'b0, 2, 1'b1, acc1);
        applyStimulus(1'b0, F3_BU, 32'h23, 32'h0, 32'h00000080, 1'b0, 2, 1'b1, acc1);
        applyStimulus(1'b0, F3_H,  32'h20, 32'h0, 32'h00007F01, 1'b0, 2, 1'b1, acc1);
        applyStimulus(1'b0, F3_H,  32'h22, 32'h0, 32'hFFFF80FF, 1'b0, 2, 1'b1, acc1);
        applyStimulus(1'b0, F3_HU, 32'h22, 32'h0, 32'h000080FF, 1'b0, 2, 1'b1, acc1);
        applyStimulus(1'b0, F3_B,  32'h21, 32'h0, 32'h0000007F, 1'b0, 2, 1'b1, acc1);
        applyStimulus(1'b1, F3_H,  32'h22, 32'hFFFF1234, 32'h0, 1'b0, 3, 1'b1, acc1);
        applyStimulus(1'b0, F3_W,  32'h20, 32'h0, 32'h12347F01, 1'b0, 2, 1'b1, acc1);
        drain();

        // Illegal accesses: no memory traffic and rdata forced to zero.
        rdSnap = readCount;
        wrSnap = writeCount;
        applyStimulus(1'b0, F3_W,   32'h21, 32'h0, 32'h0, 1'b1, 1, 1'b1, acc1);
        applyStimulus(1'b1, F3_H,   32'h23, 32'h5555, 32'h0, 1'b1, 1, 1'b1, acc1);
        applyStimulus(1'b0, 3'b011, 32'h20, 32'h0, 32'h0, 1'b1, 1, 1'b1, acc1);
        applyStimulus(1'b1, F3_BU,  32'h20, 32'h77, 32'h0, 1'b1, 1, 1'b1, acc1);
        drain();
        checkOutput("err_read_cycles", readCount - rdSnap, 32'd0);
        checkOutput("err_write_cycles", writeCount - wrSnap, 32'd0);

        // Back-pressure: second request waits until the SB finishes.
        applyStimulus(1'b1, F3_B, 32'h20, 32'h00000055, 32'h0, 1'b0, 3, 1'b1, acc1);
        applyStimulus(1'b0, F3_W, 32'h20, 32'h0, 32'h12347F55, 1'b0, 2, 1'b1, acc2);
        checkOutput("busy_accept_gap", acc2 - acc1, 32'd4);
        drain();

        // Reset during RMW_READ must abort with no write and no response.
        applyStimulus(1'b1, F3_W, 32'h30, 32'hCAFEF00D, 32'h0, 1'b0, 2, 1'b1, acc1);
        drain();
        wrSnap = writeCount;
        applyStimulus(1'b1, F3_B, 32'h31, 32'h00000099, 32'h0, 1'b0, 3, 1'b0, acc1);
        checkOutput("rmw_read_active", {31'b0, mem_read_en}, 32'd1);
        rst = 1'b0;
        #1;
        checkOutput("rst_abort_write_en", {31'b0, mem_write_en}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_ready", {31'b0, req_ready}, 32'd1);
        checkOutput("rst_abort_writes", writeCount - wrSnap, 32'd0);
        applyStimulus(1'b0, F3_W, 32'h30, 32'h0, 32'hCAFEF00D, 1'b0, 2, 1'b1, acc1);
        drain();

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
